// File: rtl/cpu_mem_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mem_pkg
// Shared definitions for the 8-bit CPU memory blocks.
//   READ_FIRST / WRITE_FIRST : read-during-write behaviour selectors
//   DEFAULT_DATA_WIDTH       : default word width in bits
//   DEFAULT_ADDR_WIDTH       : default address width (depth = 2**width)
//   clear_state_t            : state of the post-reset clear sequencer
// ---------------------------------------------------------------------------
package cpu_mem_pkg;

  localparam int READ_FIRST  = 0;
  localparam int WRITE_FIRST = 1;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_ADDR_WIDTH = 8;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } clear_state_t;

endpackage

// File: rtl/ram_clear_seq.sv
// ---------------------------------------------------------------------------
// ram_clear_seq
// Post-reset clear sequencer. After reset it walks every address once,
// asking the memory to store its initial value there, then reports ready.
// Ports:
//   clock         : rising-edge clock
//   reset         : synchronous, active-high reset
//   o_ready       : memory may accept requests
//   o_clearWe     : write the initial value this cycle
//   o_clearAddr   : address of that clear write
// ---------------------------------------------------------------------------
module ram_clear_seq
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  o_ready,
  output logic                  o_clearWe,
  output logic [ADDR_WIDTH-1:0] o_clearAddr
);

  clear_state_t          r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_ready;

  // The sweep counter doubles as the clear address. Reaching the all-ones
  // address means this is the final clear write, so ready is raised on the
  // same edge that commits that write. Without a sweep, ready rises on the
  // first edge after reset is released.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt   <= '0;
      r_ready <= 1'b0;
      if (CLEAR_ON_RESET != 0) begin
        r_state <= CLEAR;
      end else begin
        r_state <= READY;
      end
    end else begin
      case (r_state)
        CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == '1) begin
            r_state <= READY;
            r_ready <= 1'b1;
          end
        end
        READY: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= READY;
        end
      endcase
    end
  end

  // Clear writes are suppressed on a reset edge so a restart never races
  // with a stale sweep position.
  assign o_clearWe   = (r_state == CLEAR) && !reset;
  assign o_clearAddr = r_cnt;
  assign o_ready     = r_ready;

endmodule

// File: rtl/dual_port_ram.sv
// ---------------------------------------------------------------------------
// dual_port_ram
// Synchronous dual-port memory for the 8-bit CPU.
//   Port A : read-only instruction fetch, 1-cycle registered read.
//   Port B : read/write data port, 1-cycle registered read (also on writes).
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   ready               : memory accepts requests
//   a_en, a_addr        : port A read request and address
//   a_dout, a_valid     : port A read data and single-cycle valid pulse
//   b_en, b_we, b_addr  : port B request, write enable, address
//   b_din               : port B write data
//   b_dout, b_valid     : port B read data and single-cycle valid pulse
// ---------------------------------------------------------------------------
module dual_port_ram
  import cpu_mem_pkg::*;
#(
  parameter int                  DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int                  ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int                  WRITE_MODE     = READ_FIRST,
  parameter int                  CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  ready,
  input  logic                  a_en,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  output logic [DATA_WIDTH-1:0] a_dout,
  output logic                  a_valid,
  input  logic                  b_en,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic [DATA_WIDTH-1:0] b_dout,
  output logic                  b_valid
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_ready;
  logic                  w_clearWe;
  logic [ADDR_WIDTH-1:0] w_clearAddr;
  logic                  w_aAccept;
  logic                  w_bAccept;
  logic                  w_bWrite;
  logic                  w_collide;

  ram_clear_seq #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clearSeq (
    .clock       (clock),
    .reset       (reset),
    .o_ready     (w_ready),
    .o_clearWe   (w_clearWe),
    .o_clearAddr (w_clearAddr)
  );

  assign ready = w_ready;

  // Requests count only once the sweep is done and not on a reset edge.
  // A collision is a port A read of the very word port B is writing.
  assign w_aAccept = w_ready && !reset && a_en;
  assign w_bAccept = w_ready && !reset && b_en;
  assign w_bWrite  = w_bAccept && b_we;
  assign w_collide = w_aAccept && w_bWrite && (a_addr == b_addr);

  // Single write port into the array: the sweep owns it while not ready,
  // port B owns it afterwards, so the two sources never overlap.
  always_ff @(posedge clock) begin
    if (w_clearWe) begin
      r_mem[w_clearAddr] <= INIT_VALUE;
    end else if (w_bWrite) begin
      r_mem[b_addr] <= b_din;
    end
  end

  // Registered read outputs. Array reads see the pre-edge contents, which
  // is READ_FIRST naturally; WRITE_FIRST forwards the incoming write data
  // instead whenever that port's address is being written this cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_dout  <= '0;
      a_valid <= 1'b0;
      b_dout  <= '0;
      b_valid <= 1'b0;
    end else begin
      a_valid <= w_aAccept;
      b_valid <= w_bAccept;
      if (w_aAccept) begin
        if ((WRITE_MODE == WRITE_FIRST) && w_collide) begin
          a_dout <= b_din;
        end else begin
          a_dout <= r_mem[a_addr];
        end
      end
      if (w_bAccept) begin
        if ((WRITE_MODE == WRITE_FIRST) && b_we) begin
          b_dout <= b_din;
        end else begin
          b_dout <= r_mem[b_addr];
        end
      end
    end
  end

endmodule

// File: tb/tb_dual_port_ram.sv
// ---------------------------------------------------------------------------
// tb_dual_port_ram
// Scoreboard bench for dual_port_ram. Three instances share one clock:
//   rf : defaults (READ_FIRST, 16x256, clear sweep)
//   wf : WRITE_FIRST, otherwise defaults, same stimulus as rf
//   nc : CLEAR_ON_RESET=0, 8-bit words, 16 words
// Stimulus pushes expected responses into per-port queues; a monitor pops
// and compares whenever a valid pulse appears.
// ---------------------------------------------------------------------------
module tb_dual_port_ram;

  typedef struct {
    int          cyc;
    logic [15:0] data;
    bit          known;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        aEn, bEn, bWe;
  logic [7:0]  aAddr, bAddr;
  logic [15:0] bDin;

  logic        rfReady, rfAValid, rfBValid;
  logic [15:0] rfADout, rfBDout;
  logic        wfReady, wfAValid, wfBValid;
  logic [15:0] wfADout, wfBDout;

  logic        ncReset;
  logic        ncAEn, ncBEn, ncBWe;
  logic [3:0]  ncAAddr, ncBAddr;
  logic [7:0]  ncBDin;
  logic        ncReady, ncAValid, ncBValid;
  logic [7:0]  ncADout, ncBDout;

  exp_t        expQ [6][$];
  logic [15:0] lastData [6];
  bit          lastKnown [6];
  int          passCnt  = 0;
  int          totalCnt = 0;
  int          cycleNo  = 0;

  logic [15:0] refMem [256];
  bit          modelReady;
  logic [7:0]  ncMem [16];
  bit          ncKnown [16];
  bit          ncModelReady;

  dual_port_ram u_rf (
    .clock(clock), .reset(reset), .ready(rfReady),
    .a_en(aEn), .a_addr(aAddr), .a_dout(rfADout), .a_valid(rfAValid),
    .b_en(bEn), .b_we(bWe), .b_addr(bAddr), .b_din(bDin),
    .b_dout(rfBDout), .b_valid(rfBValid)
  );

  dual_port_ram #(.WRITE_MODE(1)) u_wf (
    .clock(clock), .reset(reset), .ready(wfReady),
    .a_en(aEn), .a_addr(aAddr), .a_dout(wfADout), .a_valid(wfAValid),
    .b_en(bEn), .b_we(bWe), .b_addr(bAddr), .b_din(bDin),
    .b_dout(wfBDout), .b_valid(wfBValid)
  );

  dual_port_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CLEAR_ON_RESET(0)) u_nc (
    .clock(clock), .reset(ncReset), .ready(ncReady),
    .a_en(ncAEn), .a_addr(ncAAddr), .a_dout(ncADout), .a_valid(ncAValid),
    .b_en(ncBEn), .b_we(ncBWe), .b_addr(ncBAddr), .b_din(ncBDin),
    .b_dout(ncBDout), .b_valid(ncBValid)
  );

  // Generic single-value comparison for explicit checks outside the monitor.
  task automatic checkValue(input string name, input logic [15:0] act, input logic [15:0] req);
    totalCnt++;
    if (act === req) passCnt++;
    else $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  // Expected responses land on the output one edge after they are issued.
  task automatic pushExp(input int idx, input logic [15:0] d, input bit k);
    exp_t e;
    e.cyc   = cycleNo + 1;
    e.data  = d;
    e.known = k;
    expQ[idx].push_back(e);
  endtask

  // Scoreboard check for one port: a valid pulse must match the oldest
  // expectation in data and cycle; an idle port must hold its last data.
  task automatic checkOutput(input int idx, input string name, input logic valid, input logic [15:0] dout);
    exp_t e;
    if (valid === 1'b1) begin
      totalCnt++;
      if (expQ[idx].size() == 0) begin
        $display("[TB] FAIL %s unexpected valid at cycle %0d: got valid=1 required valid=0", name, cycleNo);
      end else begin
        e = expQ[idx].pop_front();
        if (e.cyc == cycleNo && (!e.known || dout === e.data)) passCnt++;
        else $display("[TB] FAIL %s read: got 0x%0h at cycle %0d required 0x%0h at cycle %0d",
                      name, dout, cycleNo, e.data, e.cyc);
        lastData[idx]  = e.data;
        lastKnown[idx] = e.known;
      end
    end else begin
      if (expQ[idx].size() > 0 && expQ[idx][0].cyc <= cycleNo) begin
        e = expQ[idx].pop_front();
        totalCnt++;
        $display("[TB] FAIL %s missing valid at cycle %0d: got valid=%b required valid=1", name, cycleNo, valid);
      end
      if (lastKnown[idx]) begin
        totalCnt++;
        if (dout === lastData[idx]) passCnt++;
        else $display("[TB] FAIL %s hold: got 0x%0h required 0x%0h", name, dout, lastData[idx]);
      end
    end
  endtask

  // Monitor: samples 1 time unit after every rising edge. A reset edge
  // forces every read register back to zero, so the held value is zero.
  always @(posedge clock) begin
    #1;
    cycleNo++;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        lastData[i]  = '0;
        lastKnown[i] = 1'b1;
      end
    end
    if (ncReset) begin
      for (int i = 4; i < 6; i++) begin
        lastData[i]  = '0;
        lastKnown[i] = 1'b1;
      end
    end
    checkOutput(0, "rfA", rfAValid, rfADout);
    checkOutput(1, "rfB", rfBValid, rfBDout);
    checkOutput(2, "wfA", wfAValid, wfADout);
    checkOutput(3, "wfB", wfBValid, wfBDout);
    checkOutput(4, "ncA", ncAValid, {8'h00, ncADout});
    checkOutput(5, "ncB", ncBValid, {8'h00, ncBDout});
  end

  // Drive one cycle on the rf/wf pair and predict both responses from a
  // plain array: reads see old contents, WRITE_FIRST substitutes write data.
  task automatic applyStimulus(input logic ae, input logic [7:0] aa, input logic be,
                               input logic bw, input logic [7:0] ba, input logic [15:0] bd);
    logic [15:0] old;
    aEn = ae; aAddr = aa; bEn = be; bWe = bw; bAddr = ba; bDin = bd;
    if (modelReady) begin
      if (ae) begin
        old = refMem[aa];
        pushExp(0, old, 1'b1);
        pushExp(2, (be && bw && ba == aa) ? bd : old, 1'b1);
      end
      if (be) begin
        old = refMem[ba];
        pushExp(1, old, 1'b1);
        pushExp(3, bw ? bd : old, 1'b1);
        if (bw) refMem[ba] = bd;
      end
    end
    @(negedge clock);
  endtask

  // Same idea for the small no-sweep instance, tracking which words are known.
  task automatic applyNcStimulus(input logic ae, input logic [3:0] aa, input logic be,
                                 input logic bw, input logic [3:0] ba, input logic [7:0] bd);
    ncAEn = ae; ncAAddr = aa; ncBEn = be; ncBWe = bw; ncBAddr = ba; ncBDin = bd;
    if (ncModelReady) begin
      if (ae) pushExp(4, {8'h00, ncMem[aa]}, ncKnown[aa]);
      if (be) begin
        pushExp(5, {8'h00, ncMem[ba]}, ncKnown[ba]);
        if (bw) begin
          ncMem[ba]   = bd;
          ncKnown[ba] = 1'b1;
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 8'h00, 0, 0, 8'h00, 16'h0000);
  endtask

  // Two-cycle reset of the rf/wf pair, confirming the reset output values.
  task automatic doReset();
    reset = 1'b1; aEn = 0; bEn = 0; bWe = 0;
    modelReady = 1'b0;
    repeat (2) @(negedge clock);
    checkValue("resetReady", {14'h0, rfReady, wfReady}, 16'h0);
    checkValue("resetDout", rfADout | rfBDout | wfADout | wfBDout, 16'h0);
    reset = 1'b0;
  endtask

  // Random traffic while the sweep runs; nothing may be accepted. With a
  // full sweep, ready must rise exactly after the last of DEPTH cycles.
  task automatic runSweep(input int n, input bit full);
    int lowSeen = 0;
    for (int i = 0; i < n; i++) begin
      if (rfReady === 1'b0 && wfReady === 1'b0) lowSeen++;
      applyStimulus(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                    8'($urandom), 16'($urandom));
    end
    checkValue("sweepReadyLow", 16'(lowSeen), 16'(n));
    if (full) begin
      checkValue("readyAfterSweep", {14'h0, rfReady, wfReady}, 16'h3);
      for (int i = 0; i < 256; i++) refMem[i] = 16'h0000;
      modelReady = 1'b1;
    end
  endtask

  initial begin
    int r;
    logic [7:0]  ra, rb;
    logic [7:0]  wrapAddr;
    reset = 1'b1; ncReset = 1'b1;
    aEn = 0; bEn = 0; bWe = 0; aAddr = '0; bAddr = '0; bDin = '0;
    ncAEn = 0; ncBEn = 0; ncBWe = 0; ncAAddr = '0; ncBAddr = '0; ncBDin = '0;
    modelReady = 1'b0; ncModelReady = 1'b0;
    for (int i = 0; i < 6; i++) begin
      lastData[i] = '0; lastKnown[i] = 1'b1;
    end
    for (int i = 0; i < 16; i++) begin
      ncMem[i] = '0; ncKnown[i] = 1'b0;
    end
    repeat (2) @(negedge clock);

    // No-sweep instance: ready on the first edge, contents survive reset.
    ncReset = 1'b0;
    checkValue("ncReadyBeforeEdge", {15'h0, ncReady}, 16'h0);
    @(posedge clock);
    #2;
    checkValue("ncReadyFirstEdge", {15'h0, ncReady}, 16'h1);
    @(negedge clock);
    ncModelReady = 1'b1;
    applyNcStimulus(0, 4'h0, 1, 1, 4'hF, 8'hA5);
    applyNcStimulus(0, 4'h0, 0, 0, 4'h0, 8'h00);
    ncReset = 1'b1; ncModelReady = 1'b0; ncAEn = 0; ncBEn = 0; ncBWe = 0;
    repeat (2) @(negedge clock);
    ncReset = 1'b0;
    @(negedge clock);
    checkValue("ncReadyAfterReset", {15'h0, ncReady}, 16'h1);
    ncModelReady = 1'b1;
    applyNcStimulus(1, 4'hF, 1, 0, 4'hF, 8'h00);
    applyNcStimulus(0, 4'h0, 0, 0, 4'h0, 8'h00);

    // Main pair: full sweep, then reads of cleared words.
    reset = 1'b0;
    runSweep(256, 1'b1);
    applyStimulus(1, 8'h00, 0, 0, 8'h00, 16'h0);
    applyStimulus(1, 8'h7F, 0, 0, 8'h00, 16'h0);
    applyStimulus(1, 8'hFF, 0, 0, 8'h00, 16'h0);
    idle(1);

    // Write then read back, then let port A hold.
    applyStimulus(0, 8'h00, 1, 1, 8'h10, 16'hBEEF);
    applyStimulus(1, 8'h10, 0, 0, 8'h00, 16'h0);
    idle(2);

    // Same-address collision between port A read and port B write.
    applyStimulus(0, 8'h00, 1, 1, 8'h20, 16'h1111);
    applyStimulus(1, 8'h20, 1, 1, 8'h20, 16'h2222);
    applyStimulus(1, 8'h20, 0, 0, 8'h00, 16'h0);
    idle(1);

    // Random traffic with frequent forced collisions.
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      r  = $urandom_range(0, 7);
      applyStimulus(r != 0, ra, $urandom_range(0, 3) != 0, 1'($urandom), rb, 16'($urandom));
    end
    idle(1);

    // Reset in the middle of a sweep restarts it and wipes earlier data.
    applyStimulus(0, 8'h00, 1, 1, 8'hF0, 16'h5555);
    idle(1);
    doReset();
    runSweep(100, 1'b0);
    doReset();
    runSweep(256, 1'b1);
    applyStimulus(1, 8'hF0, 0, 0, 8'h00, 16'h0);
    for (int i = 0; i < 256; i++) applyStimulus(1, 8'(i), 0, 0, 8'h00, 16'h0);
    idle(1);

    // Streaming writes then back-to-back reads, wrapping past the top.
    for (int i = 0; i < 256; i++) applyStimulus(0, 8'h00, 1, 1, 8'(i), 16'(i * 3));
    wrapAddr = 8'h00;
    for (int i = 0; i < 257; i++) begin
      applyStimulus(1, wrapAddr, 0, 0, 8'h00, 16'h0);
      wrapAddr = wrapAddr + 8'h01;
    end
    idle(3);
    applyNcStimulus(0, 4'h0, 0, 0, 4'h0, 8'h00);

    for (int i = 0; i < 6; i++) checkValue($sformatf("queueEmpty%0d", i), 16'(expQ[i].size()), 16'h0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/dual_port_ram.md
Name: dual_port_ram

Overview:
Parametrised synchronous dual-port memory for the 8-bit CPU. Port A is a read-only instruction-fetch port. Port B is a read/write data port. Generalises the single-port 16x256 RAM with:
- configurable width and depth
- registered read outputs with valid strobes
- selectable read-during-write mode
- a post-reset clear sequencer that fills every word with INIT_VALUE before asserting ready

Parameters:
DATA_WIDTH, 16, word width in bits
ADDR_WIDTH, 8, address width; DEPTH = 2**ADDR_WIDTH words
WRITE_MODE, 0, 0 = READ_FIRST (reads return old data on a same-address write), 1 = WRITE_FIRST (reads return new data)
CLEAR_ON_RESET, 1, 1 = run clear sweep after reset; 0 = skip sweep, contents preserved
INIT_VALUE, 0, DATA_WIDTH-bit value written to every word by the clear sweep

Ports:
clock  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
ready  output  1  high when memory accepts requests
a_en  input  1  port A read request
a_addr  input  ADDR_WIDTH  port A address
a_dout  output  DATA_WIDTH  port A registered read data
a_valid  output  1  a_dout updated this cycle
b_en  input  1  port B request
b_we  input  1  port B write enable (qualified by b_en)
b_addr  input  ADDR_WIDTH  port B address
b_din  input  DATA_WIDTH  port B write data
b_dout  output  DATA_WIDTH  port B registered read data
b_valid  output  1  b_dout updated this cycle

Behaviour:
- Interface: one clock named clock; reset is synchronous and active-high, port named reset.
- Reset (sampled high on a clock edge):
  - ready=0, a_valid=0, b_valid=0, a_dout=0, b_dout=0.
  - Clear counter = 0.
  - FSM -> CLEAR if CLEAR_ON_RESET=1, else READY.
- FSM states:
  - CLEAR: writes INIT_VALUE to address cnt, then cnt += 1. After the write to DEPTH-1, go to READY. Sweep takes DEPTH cycles; ready rises on the edge after the last clear write.
  - READY: serves requests. Stays in READY until reset.
- While ready=0, a_en and b_en are ignored: no write, valid stays 0.
- Reset asserted mid-sweep restarts the sweep at address 0.
- Port A read, in READY with a_en=1: mem[a_addr] appears on a_dout with a_valid=1 one cycle later (latency 1).
- Port B, in READY with b_en=1:
  - b_we=1: mem[b_addr] <= b_din.
  - b_dout/b_valid follow one cycle later in all cases, including writes:
    - READ_FIRST: b_dout = previous contents.
    - WRITE_FIRST: b_dout = b_din.
- Collision (a_en, b_en&b_we, a_addr==b_addr, same cycle): a_dout returns old data (READ_FIRST) or b_din (WRITE_FIRST). Never X.
- When a port's enable is low, its dout holds its last value and its valid = 0. Valid is a single-cycle pulse per accepted request.
- Back-to-back requests are accepted every cycle. No stall, no backpressure once ready=1.
- Addresses wrap naturally; every ADDR_WIDTH value is legal.
- Contents are never X after a completed sweep. With CLEAR_ON_RESET=0, unwritten words are undefined.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - write-mode constants READ_FIRST=0 and WRITE_FIRST=1
  - the FSM state enum {CLEAR, READY}
  - the default DATA_WIDTH and ADDR_WIDTH
- Sub-module ram_clear_seq contains the FSM and counter, outputs ready plus the clear write strobe/address. The storage array and port logic stay in the top module.

Test Plan:
1. Reset for 2 cycles, defaults -> ready low for exactly 256 cycles after reset drops, then high; read A of addr 0x00, 0x7F, 0xFF each returns 0x0000 with a_valid one cycle later.
2. After ready: B write 0xBEEF to 0x10; next cycle A read 0x10 -> a_dout=0xBEEF, a_valid=1; then a_en=0 -> a_dout holds 0xBEEF, a_valid=0.
3. Collision with mem[0x20]=0x1111: B writes 0x2222 to 0x20 while A reads 0x20. READ_FIRST -> a_dout=0x1111, b_dout=0x1111. WRITE_FIRST -> both 0x2222. A following read returns 0x2222 in both modes.
4. Reset asserted at sweep cycle 100 after writing 0x5555 to 0xF0 in a prior READY phase -> sweep restarts at 0, ready after 256 more cycles, mem[0xF0]=INIT_VALUE. Requests issued during the sweep produce no valid pulse and no write.
5. Streaming: B writes addr i with i*3 for i=0..255 on consecutive cycles, then A reads 0..255 back-to-back -> 256 consecutive a_valid pulses with correct data, addr 255 wraps to 0 on the next increment.
6. CLEAR_ON_RESET=0, DATA_WIDTH=8, ADDR_WIDTH=4 -> ready=1 on the first edge after reset deasserts; 0xA5 written to 0xF before reset is still read back as 0xA5 after reset.
